instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//  Fetch stage feeding the control unit's instr input. Holds a small program memory
//  loaded over a write port, sequences a PC and presents each 20-bit instruction stable for
//  exactly as many cycles as the control unit needs to retire it. Sits between the
//  top-level and the CU.
// PARAMETERS
//  INSTR_WIDTH  20  instruction width; [19:18] class, [17:16] X1, [15:14] X2, [13:12] X3, [11:4] offset, [3:0] opcode
//  ADDR_BITS    5   program memory address width (32 words)
// PORTS
//  clk         in   1            rising-edge clock
//  rst         in   1            asynchronous, active-high reset
//  prog_we     in   1            program-memory write strobe; honoured only in IDLE
//  prog_addr   in   ADDR_BITS    write address
//  prog_data   in   INSTR_WIDTH  write data
//  start       in   1            one-cycle pulse; begins execution at PC=0; honoured only in IDLE
//  end_addr    in   ADDR_BITS    address of the last instruction; sampled on start
//  stall       in   1            freezes the hold counter and PC; instr stays stable
//  instr       out  INSTR_WIDTH  instruction to the CU; all-zero when not issuing
//  pc          out  ADDR_BITS    address of the instruction on instr
//  busy        out  1            high in FETCH/ISSUE
//  halted      out  1            high in HALT
// BEHAVIOUR
//  - Reset (async): state=IDLE, instr=0, pc=0, busy=0, halted=0, hold counter=0. Memory contents are not cleared.
//  - States: IDLE -> FETCH on start. FETCH (1 cycle, registered memory read) -> ISSUE.
//    ISSUE -> FETCH at PC+1 when the hold count expires and pc!=end_addr.
//    ISSUE -> HALT at expiry when pc==end_addr. HALT -> IDLE on start=0 & prog_we=1, or stays.
//  - Hold count by class instr[19:18]: 01 std_op=3, 10 loadR=4, 11 storeR=3.
//    The first instruction after start gets +1, covering the CU leaving RESET.
//  - Class 00 fetched in FETCH: go straight to HALT with instr=0, and pc holds that address.
//  - instr=0 in IDLE, FETCH and HALT, so the CU idles in RESET or decodes nothing.
//  - instr changes only on the clock edge where the consumer re-enters DECODE.
//  - stall=1 in ISSUE: counter and pc frozen. In FETCH, stall delays the transition to ISSUE.
//  - prog_we outside IDLE is ignored. start outside IDLE is ignored.
//  - pc increments modulo 2**ADDR_BITS.
//  - Simultaneous start and prog_we in IDLE: the write completes, and FETCH reads the new word if prog_addr==0.
//  - Reset mid-ISSUE: immediate return to IDLE, instr=0.
// CONFIGURATION
//  FETCH_WRAP_EN defined: at expiry with pc==end_addr, go to FETCH with pc=0, looping forever.
//    No extra first-instruction cycle is added on wrap. halted is never set except by a class-00 word.
//  Undefined: end-of-program goes to HALT as above.
// STRUCTURE
//  cpu_pkg (shared with CU):
//    class constants CLS_NOP=2'b00, CLS_STD=2'b01, CLS_LOAD=2'b10, CLS_STORE=2'b11
//    hold constants HOLD_STD=3, HOLD_LOAD=4, HOLD_STORE=3
//    instruction field bit positions
//    fetch state encoding
//  Sub-module instr_rom: 2**ADDR_BITS x INSTR_WIDTH, synchronous write, registered read.
//  The FSM, PC and hold counter live in instr_fetch.
// TESTING
//  1 Load mem[0]=20'h4_1002 (std_op), end_addr=0, start -> instr=20'h41002 for exactly 4 cycles,
//    then 0, halted=1, pc=0.
//  2 Load std, loadR (20'h9_4011), storeR (20'hC_4012), end_addr=2
//    -> instr hold lengths 4,4,3; pc 0,1,2; halted after.
//  3 mem[1]=20'h0 between valid words, end_addr=5 -> HALT at pc=1, instr=0, mem[2] never presented.
//  4 stall=1 for 3 cycles mid-ISSUE of a loadR -> instr held 4+3=7 cycles, pc unchanged.
//  5 Assert rst during ISSUE -> same cycle: instr=0, busy=0, state IDLE.
//    A new start re-runs from pc=0 with memory intact.
//  6 FETCH_WRAP_EN with end_addr=1 -> pc sequence 0,1,0,1,..., halted stays 0.
//    prog_we while busy leaves memory unchanged.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction layout, class/hold constants, fetch states.
package cpu_pkg;

  localparam int unsigned INSTR_WIDTH = 20;
  localparam int unsigned ADDR_BITS   = 5;
  localparam int unsigned MEM_DEPTH   = 2 ** ADDR_BITS;
  localparam int unsigned HOLD_W      = 3;

  // Class field position inside an instruction word
  localparam int unsigned CLS_HI = 19;
  localparam int unsigned CLS_LO = 18;

  localparam logic [1:0] CLS_NOP   = 2'b00;
  localparam logic [1:0] CLS_STD   = 2'b01;
  localparam logic [1:0] CLS_LOAD  = 2'b10;
  localparam logic [1:0] CLS_STORE = 2'b11;

  localparam logic [HOLD_W-1:0] HOLD_STD   = 3'd3;
  localparam logic [HOLD_W-1:0] HOLD_LOAD  = 3'd4;
  localparam logic [HOLD_W-1:0] HOLD_STORE = 3'd3;

  // Full instruction layout as seen by the control unit
  typedef struct packed {
    logic [1:0] cls;
    logic [1:0] x1;
    logic [1:0] x2;
    logic [1:0] x3;
    logic [7:0] offset;
    logic [3:0] opcode;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  // Number of cycles the CU needs to retire an instruction of a given class
  function automatic logic [HOLD_W-1:0] hold_cycles(input logic [1:0] cls);
    logic [HOLD_W-1:0] h;
    case (cls)
      CLS_STD:   h = HOLD_STD;
      CLS_LOAD:  h = HOLD_LOAD;
      CLS_STORE: h = HOLD_STORE;
      default:   h = '0;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: program load port, run control in, instruction stream out.
interface instr_fetch_if;
  import cpu_pkg::*;

  logic                   prog_we;
  logic [ADDR_BITS-1:0]   prog_addr;
  logic [INSTR_WIDTH-1:0] prog_data;
  logic                   start;
  logic [ADDR_BITS-1:0]   end_addr;
  logic                   stall;
  logic [INSTR_WIDTH-1:0] instr;
  logic [ADDR_BITS-1:0]   pc;
  logic                   busy;
  logic                   halted;

  modport master (
    output prog_we, prog_addr, prog_data, start, end_addr, stall,
    input  instr, pc, busy, halted
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start, end_addr, stall,
    output instr, pc, busy, halted
  );

endinterface

// File: rtl/instr_rom.sv
// Program memory: synchronous write, registered read with read enable.
// A read issued in the same cycle as a write to the same address returns the new word.
module instr_rom
  import cpu_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [ADDR_BITS-1:0]   waddr,
  input  logic [INSTR_WIDTH-1:0] wdata,
  input  logic                   re,
  input  logic [ADDR_BITS-1:0]   raddr,
  output logic [INSTR_WIDTH-1:0] rdata
);

  logic [INSTR_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [INSTR_WIDTH-1:0] rdata_q, rdata_d;

  // Storage array; contents survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read data select with write-first forwarding
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = (we && (waddr == raddr)) ? wdata : mem_q[raddr];
    end
  end

  // Read data register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: sequences the PC over program memory and holds each instruction
// on instr for as many cycles as the CU needs to retire it.
// Build option FETCH_WRAP_EN: end of program loops back to pc=0 instead of halting.
module instr_fetch
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  instr_fetch_if.slave bus
);

  fetch_state_e           state_q, state_d;
  logic [ADDR_BITS-1:0]   pc_q, pc_d;
  logic [ADDR_BITS-1:0]   end_q, end_d;
  logic [HOLD_W-1:0]      cnt_q, cnt_d;
  logic                   first_q, first_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   busy_q, busy_d;
  logic                   halted_q, halted_d;

  logic                   rom_we_c;
  logic                   rom_re_c;
  logic [INSTR_WIDTH-1:0] rom_data;
  logic [1:0]             rom_cls_c;

  assign rom_we_c  = (state_q == ST_IDLE) && bus.prog_we;
  assign rom_cls_c = rom_data[CLS_HI:CLS_LO];

  instr_rom u_rom (
    .clk   (clk),
    .rst   (rst),
    .we    (rom_we_c),
    .waddr (bus.prog_addr),
    .wdata (bus.prog_data),
    .re    (rom_re_c),
    .raddr (pc_d),
    .rdata (rom_data)
  );

  // Next-state, PC, hold counter and output computation
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    end_d    = end_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    instr_d  = instr_q;
    rom_re_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
          end_d   = bus.end_addr;
          first_d = 1'b1;
          instr_d = '0;
        end
      end

      ST_FETCH: begin
        if (!bus.stall) begin
          if (rom_cls_c == CLS_NOP) begin
            state_d = ST_HALT;
            instr_d = '0;
          end else begin
            state_d = ST_ISSUE;
            instr_d = rom_data;
            // Counter holds remaining cycles after this one; first word covers CU reset exit
            cnt_d   = hold_cycles(rom_cls_c) - HOLD_W'(1) + HOLD_W'(first_q);
            first_d = 1'b0;
          end
        end
      end

      ST_ISSUE: begin
        if (!bus.stall) begin
          if (cnt_q == '0) begin
            instr_d = '0;
            if (pc_q == end_q) begin
`ifdef FETCH_WRAP_EN
              state_d = ST_FETCH;
              pc_d    = '0;
`else
              state_d = ST_HALT;
`endif
            end else begin
              state_d = ST_FETCH;
              pc_d    = pc_q + ADDR_BITS'(1);
            end
          end else begin
            cnt_d = cnt_q - HOLD_W'(1);
          end
        end
      end

      ST_HALT: begin
        if (!bus.start && bus.prog_we) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Launch a memory read on every entry into FETCH
    rom_re_c = (state_d == ST_FETCH) && (state_q != ST_FETCH);
    busy_d   = (state_d == ST_FETCH) || (state_d == ST_ISSUE);
    halted_d = (state_d == ST_HALT);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      end_q    <= '0;
      cnt_q    <= '0;
      first_q  <= 1'b0;
      instr_q  <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      end_q    <= end_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      instr_q  <= instr_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  assign bus.instr  = instr_q;
  assign bus.pc     = pc_q;
  assign bus.busy   = busy_q;
  assign bus.halted = halted_q;

endmodule
